// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and default widths for the ram_arbiter block.
//   state_e  : sequencer states (IDLE, ISSUE, CAPTURE, RESP)
//   owner_e  : which requester owns the current transaction
//   DEF_ADDR_W / DEF_DATA_W : default RAM port address and data widths
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the IFU and LSU request/response channels and the
// shared RAM control port.
//   modport slave  : the arbiter (takes requests, drives responses and RAM port)
//   modport master : the surrounding core / environment
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int STRB_W = DATA_W / 8;

    // IFU channel (read-only)
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_resp_valid;
    logic              ifu_resp_ready;
    logic [DATA_W-1:0] ifu_resp_data;

    // LSU channel (read/write)
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic              lsu_req_wen;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic [STRB_W-1:0] lsu_req_wstrb;
    logic              lsu_resp_valid;
    logic              lsu_resp_ready;
    logic [DATA_W-1:0] lsu_resp_data;

    // Shared RAM port
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [STRB_W-1:0] ram_wstrb;
    logic              ram_wen;

    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata,
        input  lsu_req_wstrb, lsu_resp_ready,
        input  ram_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        output ram_raddr, ram_waddr, ram_wdata, ram_wstrb, ram_wen
    );

    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata,
        output lsu_req_wstrb, lsu_resp_ready,
        output ram_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        input  ram_raddr, ram_waddr, ram_wdata, ram_wstrb, ram_wen
    );

endinterface

// File: rtl/ram_arbiter_arb2.sv
// arb2: two-input grant logic for the RAM arbiter.
//   clock, reset : core clock, asynchronous active-low reset
//   req_i[1:0]   : bit 0 = IFU, bit 1 = LSU request
//   en_i         : a grant was accepted this cycle (updates the pointer)
//   gnt_o[1:0]   : one-hot grant, same bit order as req_i
// Macro RAM_ARB_RR_EN: when defined, simultaneous requests alternate using a
// last-grant pointer; otherwise the LSU always wins.
module arb2
    import ram_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

`ifdef RAM_ARB_RR_EN
    owner_e last_q;

    // Remember the most recent winner; reset points at LSU so IFU wins first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= OWN_LSU;
        end else if (en_i) begin
            last_q <= gnt_o[1] ? OWN_LSU : OWN_IFU;
        end else begin
            last_q <= last_q;
        end
    end

    // Round-robin grant: on a tie, the master not granted last time wins.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == OWN_LSU) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end
`else
    // Clock, reset and enable only feed the round-robin pointer.
    logic unused_s;
    assign unused_s = &{1'b0, clock, reset, en_i};

    // Fixed priority grant: LSU beats IFU.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates IFU and LSU onto the single shared RAM port and
// sequences each transaction IDLE -> ISSUE -> CAPTURE -> RESP.
//   clock : core clock
//   reset : asynchronous active-low reset
//   bus   : ram_arbiter_if.slave (request/response channels + RAM port)
// Macro RAM_ARB_RR_EN selects round-robin arbitration (see arb2).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic          clock,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;

    state_e             state_q, state_d;
    owner_e             owner_q;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [STRB_W-1:0]  wstrb_q;
    logic               ram_wen_q;
    logic [1:0]         req_s;
    logic [1:0]         gnt_s;
    logic               hs_s;

    // Requests are only visible to the arbiter in IDLE and outside reset, so
    // req_ready can never rise while a transaction is held or reset is low.
    assign req_s = (state_q == IDLE && reset) ?
                   {bus.lsu_req_valid, bus.ifu_req_valid} : 2'b00;
    assign hs_s  = |gnt_s;

    arb2 u_arb2 (
        .clock (clock),
        .reset (reset),
        .req_i (req_s),
        .en_i  (hs_s),
        .gnt_o (gnt_s)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP: begin
                if ((owner_q == OWN_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and response-valid outputs.
    always_comb begin
        bus.ifu_req_ready  = gnt_s[0];
        bus.lsu_req_ready  = gnt_s[1];
        bus.ifu_resp_valid = 1'b0;
        bus.lsu_resp_valid = 1'b0;
        if (state_q == RESP) begin
            if (owner_q == OWN_LSU) begin
                bus.lsu_resp_valid = 1'b1;
            end else begin
                bus.ifu_resp_valid = 1'b1;
            end
        end else begin
            bus.ifu_resp_valid = 1'b0;
            bus.lsu_resp_valid = 1'b0;
        end
    end

    // Request latch and RAM port registers. The RAM port registers are loaded
    // on the handshake edge so they show the request during ISSUE; the address
    // then simply holds, while the write pulse and strobes clear after one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q   <= OWN_IFU;
            wr_q      <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            wstrb_q   <= {STRB_W{1'b0}};
            ram_wen_q <= 1'b0;
            rdata_q   <= {DATA_W{1'b0}};
        end else begin
            ram_wen_q <= 1'b0;
            wstrb_q   <= {STRB_W{1'b0}};
            if (hs_s) begin
                owner_q <= gnt_s[1] ? OWN_LSU : OWN_IFU;
                addr_q  <= gnt_s[1] ? bus.lsu_req_addr : bus.ifu_req_addr;
                wr_q    <= gnt_s[1] & bus.lsu_req_wen;
                if (gnt_s[1] && bus.lsu_req_wen) begin
                    ram_wen_q <= 1'b1;
                    wstrb_q   <= bus.lsu_req_wstrb;
                    wdata_q   <= bus.lsu_req_wdata;
                end else begin
                    wdata_q   <= wdata_q;
                end
            end else begin
                owner_q <= owner_q;
            end
            // Read data is valid the cycle after the address was presented.
            if (state_q == CAPTURE) begin
                rdata_q <= wr_q ? {DATA_W{1'b0}} : bus.ram_rdata;
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    assign bus.ram_raddr     = addr_q;
    assign bus.ram_waddr     = addr_q;
    assign bus.ram_wdata     = wdata_q;
    assign bus.ram_wstrb     = wstrb_q;
    assign bus.ram_wen       = ram_wen_q;
    assign bus.ifu_resp_data = rdata_q;
    assign bus.lsu_resp_data = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter with a small RAM model,
// a table of single transactions and hand-written multi-cycle sequences.
module tb_ram_arbiter;

    typedef struct {
        bit          is_lsu;
        bit          wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] exp_data;
    } vec_t;

    typedef struct {
        bit          is_lsu;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb_q[$];
    logic prev_wen = 1'b0;
    logic mem_loaded = 1'b0;
    logic [63:0] mem [0:7];
    vec_t vecs [9];

    always #5 clk = ~clk;

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] st);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // RAM model: registered read, byte-strobed write.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            mem[0] <= 64'hDEAD_BEEF_0000_0001;
            mem[1] <= 64'h0123_4567_89AB_CDEF;
            mem[2] <= 64'hAAAA_BBBB_CCCC_DDDD;
            mem[3] <= 64'h5555_6666_7777_8888;
            for (int i = 4; i < 8; i++) mem[i] <= 64'h0;
            mem_loaded <= 1'b1;
        end else begin
            bus.ram_rdata <= mem[bus.ram_raddr[5:3]];
            if (bus.ram_wen)
                mem[bus.ram_waddr[5:3]] <= merge(mem[bus.ram_waddr[5:3]], bus.ram_wdata, bus.ram_wstrb);
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0b expected %0b", name, act, exp);
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic sb_pop(input bit is_lsu, input logic [63:0] data);
        exp_t e;
        if (sb_q.size() == 0) begin
            check1("spurious_resp", 1'b1, 1'b0);
        end else begin
            e = sb_q.pop_front();
            check1("resp_owner", is_lsu, e.is_lsu);
            check64("resp_data", data, e.data);
        end
    endtask

    // Response monitor and RAM write-pulse checks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ram_wen) check1("wen_single_cycle", prev_wen, 1'b0);
            if (bus.ifu_resp_valid || bus.lsu_resp_valid)
                check1("resp_onehot", bus.ifu_resp_valid & bus.lsu_resp_valid, 1'b0);
            if (bus.ifu_resp_valid && bus.ifu_resp_ready) sb_pop(1'b0, bus.ifu_resp_data);
            if (bus.lsu_resp_valid && bus.lsu_resp_ready) sb_pop(1'b1, bus.lsu_resp_data);
        end
        prev_wen <= bus.ram_wen;
    end

    task automatic push_exp(input bit is_lsu, input logic [63:0] data);
        exp_t e;
        e.is_lsu = is_lsu;
        e.data   = data;
        sb_q.push_back(e);
    endtask

    task automatic do_req(input vec_t v);
        int n;
        logic rdy;
        @(posedge clk); #1;
        if (v.is_lsu) begin
            bus.lsu_req_valid = 1'b1;
            bus.lsu_req_addr  = v.addr;
            bus.lsu_req_wen   = v.wen;
            bus.lsu_req_wdata = v.wdata;
            bus.lsu_req_wstrb = v.wstrb;
        end else begin
            bus.ifu_req_valid = 1'b1;
            bus.ifu_req_addr  = v.addr;
        end
        n = 0;
        @(negedge clk);
        rdy = v.is_lsu ? bus.lsu_req_ready : bus.ifu_req_ready;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
            rdy = v.is_lsu ? bus.lsu_req_ready : bus.ifu_req_ready;
        end
        check1("req_accepted", rdy, 1'b1);
        if (rdy) push_exp(v.is_lsu, v.exp_data);
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
    endtask

    task automatic check_issue(input vec_t v);
        @(negedge clk);
        check1("issue_wen", bus.ram_wen, v.wen);
        check64("issue_raddr", bus.ram_raddr, v.addr);
        check64("issue_waddr", bus.ram_waddr, v.addr);
        if (v.wen) begin
            check64("issue_wdata", bus.ram_wdata, v.wdata);
            check64("issue_wstrb", {56'h0, bus.ram_wstrb}, {56'h0, v.wstrb});
        end
        @(negedge clk);
        check1("capture_wen", bus.ram_wen, 1'b0);
        check64("capture_wstrb", {56'h0, bus.ram_wstrb}, 64'h0);
        check1("capture_resp_valid", v.is_lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid, 1'b0);
        @(negedge clk);
        check1("resp_latency", v.is_lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid, 1'b1);
        check1("nonowner_resp_valid", v.is_lsu ? bus.ifu_resp_valid : bus.lsu_resp_valid, 1'b0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_int("drain", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v);
        do_req(v);
        check_issue(v);
        wait_drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_ifu_req_ready"}, bus.ifu_req_ready, 1'b0);
        check1({tag, "_lsu_req_ready"}, bus.lsu_req_ready, 1'b0);
        check1({tag, "_ifu_resp_valid"}, bus.ifu_resp_valid, 1'b0);
        check1({tag, "_lsu_resp_valid"}, bus.lsu_resp_valid, 1'b0);
        check64({tag, "_ifu_resp_data"}, bus.ifu_resp_data, 64'h0);
        check64({tag, "_lsu_resp_data"}, bus.lsu_resp_data, 64'h0);
        check64({tag, "_raddr"}, bus.ram_raddr, 64'h0);
        check64({tag, "_waddr"}, bus.ram_waddr, 64'h0);
        check64({tag, "_wdata"}, bus.ram_wdata, 64'h0);
        check64({tag, "_wstrb"}, {56'h0, bus.ram_wstrb}, 64'h0);
        check1({tag, "_wen"}, bus.ram_wen, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   got [4];
        bit   exp_g [4];
        int   g;
        int   n;
        int   bad;

        //         lsu   wen   addr                   wdata                  wstrb  expected data
        vecs[0] = '{1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0,                 8'h00, 64'hDEAD_BEEF_0000_0001};
        vecs[1] = '{1'b1, 1'b1, 64'h0000_0000_8000_0010, 64'h1122_3344_5566_7788, 8'h0F, 64'h0};
        vecs[2] = '{1'b1, 1'b0, 64'h0000_0000_8000_0010, 64'h0,                 8'h00, 64'hAAAA_BBBB_5566_7788};
        vecs[3] = '{1'b0, 1'b0, 64'h0000_0000_8000_0010, 64'h0,                 8'h00, 64'hAAAA_BBBB_5566_7788};
        vecs[4] = '{1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFEE_DDCC_BBAA_9988, 8'hC3, 64'h0};
        vecs[5] = '{1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'h0,                 8'h00, 64'hFFEE_BEEF_0000_9988};
        vecs[6] = '{1'b1, 1'b1, 64'h0000_0000_8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0};
        vecs[7] = '{1'b0, 1'b0, 64'h0000_0000_8000_0008, 64'h0,                 8'h00, 64'h0123_4567_89AB_CDEF};
        vecs[8] = '{1'b1, 1'b0, 64'h0000_0000_8000_0018, 64'h0,                 8'h00, 64'h5555_6666_7777_8888};

`ifdef RAM_ARB_RR_EN
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        // Reset state, with both requests raised to show ready stays low.
        bus.ifu_req_valid  = 1'b1;
        bus.ifu_req_addr   = 64'h0;
        bus.ifu_resp_ready = 1'b1;
        bus.lsu_req_valid  = 1'b1;
        bus.lsu_req_addr   = 64'h0;
        bus.lsu_req_wen    = 1'b0;
        bus.lsu_req_wdata  = 64'h0;
        bus.lsu_req_wstrb  = 8'h00;
        bus.lsu_resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        rst_n = 1'b1;

        // Table of single transactions.
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Both requesters valid continuously for four transactions.
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 64'h0000_0000_8000_0018;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 64'h0000_0000_8000_0008;
        bus.lsu_req_wen   = 1'b0;
        g = 0;
        n = 0;
        while (g < 4 && n < 80) begin
            @(negedge clk);
            n++;
            if (bus.ifu_req_ready || bus.lsu_req_ready)
                check1("arb_ready_onehot", bus.ifu_req_ready & bus.lsu_req_ready, 1'b0);
            if (bus.lsu_req_ready) begin
                got[g] = 1'b1;
                push_exp(1'b1, 64'h0123_4567_89AB_CDEF);
                g++;
            end else if (bus.ifu_req_ready) begin
                got[g] = 1'b0;
                push_exp(1'b0, 64'h5555_6666_7777_8888);
                g++;
            end
        end
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        check_int("arb_grant_count", g, 4);
        for (int i = 0; i < 4; i++) check1($sformatf("arb_grant_%0d", i), got[i], exp_g[i]);
        wait_drain();

        // LSU response held for 10 cycles while IFU waits.
        bus.lsu_resp_ready = 1'b0;
        v = '{1'b1, 1'b0, 64'h0000_0000_8000_0008, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF};
        do_req(v);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 64'h0000_0000_8000_0018;
        n = 0;
        @(negedge clk);
        while (!bus.lsu_resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check1("stall_resp_seen", bus.lsu_resp_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check1("stall_valid_held", bus.lsu_resp_valid, 1'b1);
            check64("stall_data_held", bus.lsu_resp_data, 64'h0123_4567_89AB_CDEF);
            check1("stall_ifu_ready", bus.ifu_req_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.lsu_resp_ready = 1'b1;
        @(negedge clk);
        check1("release_cycle_ifu_ready", bus.ifu_req_ready, 1'b0);
        @(negedge clk);
        check1("ifu_grant_after_release", bus.ifu_req_ready, 1'b1);
        if (bus.ifu_req_ready) push_exp(1'b0, 64'h5555_6666_7777_8888);
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0;
        wait_drain();

        // Reset asserted while a write is in ISSUE.
        v = '{1'b1, 1'b1, 64'h0000_0000_8000_0018, 64'h0, 8'hFF, 64'h0};
        do_req(v);
        check1("pre_reset_wen", bus.ram_wen, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.ifu_resp_valid || bus.lsu_resp_valid || bus.ram_wen) bad++;
        end
        check_int("no_resp_after_reset", bad, 0);
        v = '{1'b0, 1'b0, 64'h0000_0000_8000_0018, 64'h0, 8'h00, 64'h5555_6666_7777_8888};
        run_vec(v);

        // IFU raises and drops its request while LSU is being served.
        v = '{1'b1, 1'b0, 64'h0000_0000_8000_0010, 64'h0, 8'h00, 64'hAAAA_BBBB_5566_7788};
        do_req(v);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 64'h0000_0000_8000_0000;
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0;
        wait_drain();
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.ifu_req_ready || bus.lsu_req_ready || bus.ifu_resp_valid ||
                bus.lsu_resp_valid || bus.ram_wen) bad++;
        end
        check_int("no_spurious_grant", bad, 0);
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b1;
        @(negedge clk);
        check1("idle_immediate_grant", bus.ifu_req_ready, 1'b1);
        if (bus.ifu_req_ready) push_exp(1'b0, 64'hFFEE_BEEF_0000_9988);
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0;
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single shared DPI-backed RAM control port of the NPC core.
- Requesters: instruction fetch (IFU, read-only) and load/store unit (LSU, read/write).
- Each request is latched, issued to the RAM for exactly one cycle, and the read data is captured and returned to the requester through a valid/ready response channel.
- One transaction is outstanding at a time.

Parameters:
- ADDR_W, 64, address width of the RAM port.
- DATA_W, 64, data width; strobe width is DATA_W/8.

Ports:
- clock  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ifu_req_valid  in  1  IFU read request valid.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  ADDR_W  IFU read address.
- ifu_resp_valid  out  1  IFU read data valid.
- ifu_resp_ready  in  1  IFU accepts the response.
- ifu_resp_data  out  DATA_W  IFU read data.
- lsu_req_valid  in  1  LSU request valid.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_req_addr  in  ADDR_W  LSU address (read or write).
- lsu_req_wen  in  1  1 = write, 0 = read.
- lsu_req_wdata  in  DATA_W  LSU write data.
- lsu_req_wstrb  in  DATA_W/8  LSU byte strobes.
- lsu_resp_valid  out  1  LSU response valid (reads and writes).
- lsu_resp_ready  in  1  LSU accepts the response.
- lsu_resp_data  out  DATA_W  LSU read data; 0 for writes.
- ram_raddr  out  ADDR_W  RAM read address.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_raddr is sampled.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_wstrb  out  DATA_W/8  RAM write strobes.
- ram_wen  out  1  RAM write enable.

Behaviour:
- Clock and reset:
  - One clock, `clock`.
  - `reset` is asynchronous and active-low: assertion forces state at once, independent of `clock`.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - Grants one requester whose req_valid is high.
  - req_ready is combinationally high for the winner only, and only in IDLE.
  - On handshake, latch owner, addr, wen, wdata and wstrb, then go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE, one cycle:
  - Drive ram_raddr/ram_waddr = latched addr.
  - For a write: ram_wdata and ram_wstrb from the latch, ram_wen = 1.
  - For a read: ram_wen = 0.
  - Next state CAPTURE.
- CAPTURE, one cycle:
  - Register ram_rdata into the response data register (reads), or 0 (writes).
  - Next state RESP.
- RESP:
  - Owner's resp_valid = 1 and resp_data is stable.
  - On resp_ready, go to IDLE.
  - Hold indefinitely while resp_ready is low; no new grant while held.
- Latency: handshake at cycle N → ram_wen/raddr driven in cycle N+1 → resp_valid from cycle N+3. Best-case throughput is one transaction per 4 cycles.
- ram_wen:
  - High only in ISSUE on a write.
  - Never high in two consecutive cycles.
  - Never high in the same cycle as reset assertion.
- Output values outside ISSUE:
  - ram_raddr/ram_waddr hold the last issued address.
  - ram_wstrb = 0.
- Arbitration when both are valid in IDLE: LSU wins (fixed priority). Overridden by the Optional Feature.
- A requester may drop req_valid before it is accepted; no state change results.
- Non-owner resp_valid is always 0.
- Reset values:
  - state = IDLE.
  - All req_ready and resp_valid = 0.
  - resp_data = 0.
  - ram_raddr = ram_waddr = ram_wdata = 0.
  - ram_wstrb = 0, ram_wen = 0.
- Reset asserted mid-transaction (any state):
  - Transaction is discarded and no response is delivered.
  - A write in ISSUE is suppressed, because ram_wen is forced low asynchronously.
- Addresses and data pass through unchanged: no alignment checking, no width conversion.

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_grant register (reset value = LSU) marks the last winner.
  - On simultaneous requests, the master not granted last wins.
  - last_grant updates only on a req handshake.
- Undefined: fixed LSU priority. No last_grant register exists.

Decomposition:
- Package ram_arb_pkg:
  - state enum {IDLE, ISSUE, CAPTURE, RESP}.
  - owner enum {OWN_IFU, OWN_LSU}.
  - ADDR_W/DATA_W default constants.
- Sub-module arb2: two-input grant logic with optional round-robin pointer.
  - Inputs: two req lines, the enable, clock and reset.
  - Outputs: one-hot grant.

Test Plan:
- IFU read 0x8000_0000; RAM model returns 0xDEAD_BEEF_0000_0001 → ifu_resp_valid in cycle 3 after the handshake with that data; ram_wen stays 0.
- LSU write addr 0x8000_0010, wdata 0x1122_3344_5566_7788, wstrb 0x0F → ram_wen high exactly one cycle with matching waddr/wdata/wstrb; lsu_resp_valid with data 0.
- Both requesters valid continuously, 4 transactions:
  - Without RAM_ARB_RR_EN: grants LSU, LSU, LSU, LSU.
  - With RAM_ARB_RR_EN: grants IFU, LSU, IFU, LSU.
- lsu_resp_ready held low 10 cycles → lsu_resp_valid and data held stable; ifu_req_ready stays 0 throughout; IFU is granted the cycle after release.
- reset pulled low during ISSUE of a write → ram_wen falls immediately; all outputs return to reset values; after release, no response is delivered and the next request completes normally.
- Requester drops req_valid while the other is being served → no spurious grant; the FSM returns to IDLE and stays there.
